// File: rtl/adt7301_scanner.sv
// adt7301_scanner: round-robin SPI poller for three ADT7301 temperature sensors.
// Each scan selects sensors 0..2 in turn, shifts in one 16-bit frame per sensor,
// stores the 14-bit reading when the two leading bits are zero, and otherwise
// flags a sticky frame error. Scans repeat POLL_PERIOD cycles after the last gap.
// Optional feature: define ADT_ALARM_EN to enable the per-sensor threshold alarm.
module adt7301_scanner #(
  parameter int CLK_DIV     = 4,
  parameter int POLL_PERIOD = 40000
) (
  input  logic             dtc_clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [2:0]       adt_cs_b,
  output logic             adt_sclk,
  output logic             adt_din,
  input  logic             adt_dout,
  output logic [2:0][13:0] temp,
  output logic             temp_vld,
  output logic [1:0]       temp_idx,
  output logic [2:0]       frame_err,
  output logic             busy,
  input  logic [13:0]      thr,
  input  logic             alarm_clr,
  output logic [2:0]       alarm
);

  // One shared counter times every phase, so it must hold the longest of them.
  localparam int CW_RAW = $clog2(POLL_PERIOD + 2 * CLK_DIV + 1);
  localparam int CW     = (CW_RAW < 2) ? 2 : CW_RAW;
  localparam logic [CW-1:0] DIV     = CW'(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_M1  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] POLL_M1 = CW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift_reg;
  logic [1:0]    idx;

  logic short_done, period_done, release_now, frame_ok;

  assign short_done  = (cnt == DIV_M1);
  assign period_done = (cnt == PER_M1);
  assign release_now = (state == CS_HOLD) && short_done;
  assign frame_ok    = (shift_reg[15:14] == 2'b00);
  assign adt_din     = 1'b0;

  // State register.
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a dropped enable only takes effect at the end of a gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable) state_nxt = CS_SETUP;
      CS_SETUP: if (short_done) state_nxt = SHIFT;
      SHIFT:    if (period_done && bit_cnt == 4'd15) state_nxt = CS_HOLD;
      CS_HOLD:  if (short_done) state_nxt = GAP;
      GAP: begin
        if (short_done) begin
          if (!enable)          state_nxt = IDLE;
          else if (idx < 2'd2)  state_nxt = CS_SETUP;
          else                  state_nxt = WAIT;
        end
      end
      WAIT:     if (cnt == POLL_M1) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode: chip select and SCLK come straight from registered state.
  always_comb begin
    adt_cs_b = 3'b111;
    adt_sclk = 1'b1;
    busy     = 1'b0;
    case (state)
      CS_SETUP, CS_HOLD: begin
        adt_cs_b[idx] = 1'b0;
        busy          = 1'b1;
      end
      SHIFT: begin
        adt_cs_b[idx] = 1'b0;
        busy          = 1'b1;
        adt_sclk      = (cnt >= DIV);
      end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

  // Phase timing, bit counting, serial capture and sensor index.
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      idx       <= '0;
    end else begin
      if (state == IDLE || state_nxt != state || (state == SHIFT && period_done))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (state != SHIFT)   bit_cnt <= '0;
      else if (period_done) bit_cnt <= bit_cnt + 4'd1;

      if (state == SHIFT && cnt == DIV)
        shift_reg <= {shift_reg[14:0], adt_dout};

      if (state == IDLE)
        idx <= '0;
      else if (state == GAP && short_done && state_nxt == CS_SETUP)
        idx <= idx + 2'd1;
    end
  end

  // Readout on CS release: store a good frame and pulse valid, else flag an error.
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) begin
      temp      <= '0;
      temp_vld  <= 1'b0;
      temp_idx  <= '0;
      frame_err <= '0;
    end else begin
      temp_vld <= release_now && frame_ok;
      if (release_now) begin
        if (frame_ok) begin
          temp[idx] <= shift_reg[13:0];
          temp_idx  <= idx;
        end else begin
          frame_err[idx] <= 1'b1;
        end
      end
    end
  end

`ifdef ADT_ALARM_EN
  logic [2:0] alarm_set;

  // A good frame above the signed threshold raises that sensor's alarm.
  always_comb begin
    alarm_set = '0;
    if (release_now && frame_ok && ($signed(shift_reg[13:0]) > $signed(thr)))
      alarm_set[idx] = 1'b1;
  end

  // Sticky alarms; a new exceed wins over a simultaneous clear.
  always_ff @(posedge dtc_clk or negedge rst_n) begin
    if (!rst_n) alarm <= '0;
    else        alarm <= (alarm & {3{~alarm_clr}}) | alarm_set;
  end
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{thr, alarm_clr};
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_adt7301_scanner.sv
// tb_adt7301_scanner: self-checking bench for adt7301_scanner with three
// behavioural ADT7301 sensor models on the shared data line.
module tb_adt7301_scanner;

  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 100;
  localparam int CS_LOW      = CLK_DIV * (1 + 32 + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [2:0]       adt_cs_b;
  logic             adt_sclk;
  logic             adt_din;
  logic             adt_dout;
  logic [2:0][13:0] temp;
  logic             temp_vld;
  logic [1:0]       temp_idx;
  logic [2:0]       frame_err;
  logic             busy;
  logic [13:0]      thr;
  logic             alarm_clr;
  logic [2:0]       alarm;

  adt7301_scanner #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
    .dtc_clk(clk), .rst_n(rst_n), .enable(enable),
    .adt_cs_b(adt_cs_b), .adt_sclk(adt_sclk), .adt_din(adt_din), .adt_dout(adt_dout),
    .temp(temp), .temp_vld(temp_vld), .temp_idx(temp_idx), .frame_err(frame_err),
    .busy(busy), .thr(thr), .alarm_clr(alarm_clr), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Sensor models: MSB appears at CS fall, each later bit after an SCLK fall.
  logic [15:0] sensor_word [3];
  logic [2:0]  cs_prev = 3'b111;
  int          fall_cnt = 0;
  int          sel;
  int          pos;

  always @(negedge adt_sclk or adt_cs_b) begin
    if (adt_cs_b !== cs_prev) begin
      cs_prev  = adt_cs_b;
      fall_cnt = 0;
    end else begin
      fall_cnt = fall_cnt + 1;
    end
  end

  always_comb begin
    sel = -1;
    for (int i = 0; i < 3; i++) if (adt_cs_b[i] == 1'b0) sel = i;
    pos = (fall_cnt == 0) ? 15 : 16 - fall_cnt;
    adt_dout = 1'b0;
    if (sel >= 0 && pos >= 0) adt_dout = sensor_word[sel][pos];
  end

  // Reference model state and scoreboard of expected valid pulses.
  typedef struct packed { logic [1:0] idx; logic [13:0] val; } ev_t;
  ev_t              exp_q[$];
  logic [2:0][13:0] temp_m;
  logic [2:0]       ferr_m;
  logic [2:0]       alarm_m;
  int               exp_vld;
  int               vld_cnt;
  int               low_cnt [3];
  logic [2:0]       seen_low;

  typedef struct {
    logic [15:0]      w0, w1, w2;
    logic [2:0][13:0] exp_temp;
    logic [2:0]       exp_ferr;
    logic [2:0]       exp_alarm;
    int               exp_vld;
  } vec_t;
  vec_t tbl [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] alarm_expect(input logic [2:0] m);
`ifdef ADT_ALARM_EN
    return m;
`else
    return m & 3'b000;
`endif
  endfunction

  task automatic model_reset();
    temp_m  = '0;
    ferr_m  = '0;
    alarm_m = '0;
    exp_q.delete();
  endtask

  task automatic start_window();
    exp_vld = 0;
    vld_cnt = 0;
  endtask

  // Load sensor words and predict the first n sensor frames of a scan.
  task automatic apply_stimulus(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input int n);
    ev_t ev;
    sensor_word[0] = w0;
    sensor_word[1] = w1;
    sensor_word[2] = w2;
    for (int i = 0; i < n; i++) begin
      if (sensor_word[i][15:14] == 2'b00) begin
        temp_m[i] = sensor_word[i][13:0];
        ev.idx = 2'(i);
        ev.val = sensor_word[i][13:0];
        exp_q.push_back(ev);
        exp_vld++;
        if ($signed(sensor_word[i][13:0]) > $signed(thr)) alarm_m[i] = 1'b1;
      end else begin
        ferr_m[i] = 1'b1;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [2:0][13:0] et,
                              input logic [2:0] ef, input logic [2:0] ea, input int ev);
    check({tag, ".temp"},      64'(temp), 64'(et));
    check({tag, ".frame_err"}, 64'(frame_err), 64'(ef));
    check({tag, ".alarm"},     64'(alarm), 64'(alarm_expect(ea)));
    check({tag, ".vld_count"}, 64'(vld_cnt), 64'(ev));
    check({tag, ".pending"},   64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_busy(input logic level, input int limit, input string what);
    int n = 0;
    while (busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(what, 64'(busy), 64'(level));
  endtask

  task automatic wait_cs(input int i, input logic level, input int limit, output int n);
    n = 0;
    while (adt_cs_b[i] !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_cs%0d_%0b", i, level), 64'(adt_cs_b[i]), 64'(level));
  endtask

  // Monitor: valid pulses against the scoreboard, CS width and exclusivity.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) low_cnt[i] = 0;
    end else begin
      if (temp_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_vld", 64'(temp_idx), 64'(3));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("vld_idx", 64'(temp_idx), 64'(e.idx));
          check("vld_temp", 64'(temp[e.idx]), 64'(e.val));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (adt_cs_b[i] == 1'b0) begin
          low_cnt[i]++;
          seen_low[i] = 1'b1;
        end else if (low_cnt[i] != 0) begin
          check($sformatf("cs%0d_low_len", i), 64'(low_cnt[i]), 64'(CS_LOW));
          low_cnt[i] = 0;
        end
      end
      check("cs_onehot", 64'($countones(~adt_cs_b) <= 1), 64'(1));
    end
  end

  initial begin
    int n;
    logic [15:0] w [3];

    tbl[0] = '{16'h0C80, 16'h3F38, 16'h0000, {14'h0000, 14'h3F38, 14'h0C80}, 3'b000, 3'b000, 3};
    tbl[1] = '{16'h1FFF, 16'h8123, 16'h2001, {14'h2001, 14'h3F38, 14'h1FFF}, 3'b010, 3'b001, 2};
    tbl[2] = '{16'h4000, 16'h0005, 16'hC000, {14'h2001, 14'h0005, 14'h1FFF}, 3'b111, 3'b001, 1};

    rst_n = 1'b0; enable = 1'b0; thr = 14'h0C80; alarm_clr = 1'b0; seen_low = '0;
    sensor_word[0] = '0; sensor_word[1] = '0; sensor_word[2] = '0;
    model_reset();
    start_window();
    repeat (3) @(negedge clk);
    check("rst.cs_b", 64'(adt_cs_b), 64'(3'b111));
    check("rst.sclk", 64'(adt_sclk), 64'(1));
    check("rst.din", 64'(adt_din), 64'(0));
    check("rst.temp", 64'(temp), 64'(0));
    check("rst.vld", 64'(temp_vld), 64'(0));
    check("rst.idx", 64'(temp_idx), 64'(0));
    check("rst.ferr", 64'(frame_err), 64'(0));
    check("rst.alarm", 64'(alarm), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));

    // Table-driven scans; expectations accumulate across rows.
    apply_stimulus(tbl[0].w0, tbl[0].w1, tbl[0].w2, 3);
    rst_n = 1'b1; enable = 1'b1;
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        start_window();
        apply_stimulus(tbl[r].w0, tbl[r].w1, tbl[r].w2, 3);
      end
      wait_busy(1'b1, 300, "tbl.busy_rise");
      wait_busy(1'b0, 2000, "tbl.busy_fall");
      check_output($sformatf("tbl%0d", r), tbl[r].exp_temp, tbl[r].exp_ferr,
                   tbl[r].exp_alarm, tbl[r].exp_vld);
    end

    // Randomized scans against the model.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin
        w[i] = 16'($urandom);
        w[i][15:14] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      start_window();
      apply_stimulus(w[0], w[1], w[2], 3);
      wait_busy(1'b1, 300, "rnd.busy_rise");
      wait_busy(1'b0, 2000, "rnd.busy_fall");
      check_output($sformatf("rnd%0d", k), temp_m, ferr_m, alarm_m, exp_vld);
    end

    // Poll gap from last CS release to next sensor-0 select.
    start_window();
    apply_stimulus(16'h0010, 16'h0020, 16'h0030, 3);
    apply_stimulus(16'h0010, 16'h0020, 16'h0030, 3);
    wait_busy(1'b1, 300, "gap.busy_rise");
    wait_cs(2, 1'b0, 1000, n);
    wait_cs(2, 1'b1, 1000, n);
    wait_cs(0, 1'b0, 1000, n);
    check("poll_gap", 64'(n), 64'(CLK_DIV + POLL_PERIOD + 1));
    wait_busy(1'b0, 2000, "gap.busy_fall");
    check_output("gap", temp_m, ferr_m, alarm_m, exp_vld);

    // Enable dropped during sensor 0 bit 5.
    enable = 1'b0;
    repeat (POLL_PERIOD + 20) @(negedge clk);
    start_window();
    apply_stimulus(16'h0123, 16'h0456, 16'h0789, 1);
    seen_low = '0;
    enable = 1'b1;
    wait_cs(0, 1'b0, 50, n);
    repeat (CLK_DIV + 5 * 2 * CLK_DIV + 2) @(negedge clk);
    enable = 1'b0;
    repeat (600) @(negedge clk);
    check("endrop.seen1", 64'(seen_low[1]), 64'(0));
    check("endrop.seen2", 64'(seen_low[2]), 64'(0));
    check("endrop.busy", 64'(busy), 64'(0));
    check("endrop.cs_b", 64'(adt_cs_b), 64'(3'b111));
    check_output("endrop", temp_m, ferr_m, alarm_m, exp_vld);

    // Asynchronous reset during sensor 2 shift.
    start_window();
    apply_stimulus(16'h0101, 16'h0202, 16'h0303, 2);
    enable = 1'b1;
    wait_cs(2, 1'b0, 1000, n);
    repeat (CLK_DIV + 20) @(negedge clk);
    check("mrst.pre_pending", 64'(exp_q.size()), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("mrst.cs_b", 64'(adt_cs_b), 64'(3'b111));
    check("mrst.sclk", 64'(adt_sclk), 64'(1));
    check("mrst.temp", 64'(temp), 64'(0));
    check("mrst.busy", 64'(busy), 64'(0));
    check("mrst.ferr", 64'(frame_err), 64'(0));
    model_reset();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Threshold alarm, then a clear coinciding with a new exceed.
    start_window();
    apply_stimulus(16'h0C81, 16'h0100, 16'h0000, 3);
    enable = 1'b1;
    wait_busy(1'b1, 300, "alm.busy_rise");
    wait_busy(1'b0, 2000, "alm.busy_fall");
    check_output("alm", temp_m, ferr_m, alarm_m, exp_vld);
    check("alm.set", 64'(alarm), 64'(alarm_expect(3'b001)));
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    alarm_m = '0;
    check("alm.clr", 64'(alarm), 64'(0));
    start_window();
    apply_stimulus(16'h0C81, 16'h0100, 16'h0000, 3);
    wait_cs(0, 1'b0, 300, n);
    repeat (CS_LOW - 1) @(negedge clk);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    check("alm.set_beats_clr", 64'(alarm), 64'(alarm_expect(3'b001)));
    wait_busy(1'b0, 2000, "alm2.busy_fall");
    check_output("alm2", temp_m, ferr_m, alarm_m, exp_vld);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
